range_counter: RTL and testbench

- Window generator. Watches an externally supplied free-running counter value. When the counter equals a loaded start value (on_count), it asserts `active` for exactly `range_duration` clock cycles.
- While the window is open it reports the cycles elapsed within it.
- Used for timing windows in the display/game pipeline, e.g. horizontal/vertical object spans driven by pixel/line counters.

---
 rtl/range_counter_if.sv | 27 ++
 rtl/range_counter.sv | 75 +++++++
 tb/tb_range_counter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : range_counter_if
// Purpose  : Bundles the compare/load inputs and window outputs of
//            range_counter.
// Signals  : counter   - external free-running count being watched
//            load      - capture on_count as the new window start
//            on_count  - new window start value
//            active    - high while the window is open
//            elapsed   - cycles elapsed inside the open window, 0 otherwise
// Modports : master drives counter/load/on_count; slave drives active/elapsed.
// Revision : 1.0 - initial release
// ============================================================================
interface range_counter_if #(
  parameter int COUNTER_WIDTH = 8,
  parameter int ELAPSED_WIDTH = 4
);
  logic [COUNTER_WIDTH-1:0] counter;
  logic                     load;
  logic [COUNTER_WIDTH-1:0] on_count;
  logic                     active;
  logic [ELAPSED_WIDTH-1:0] elapsed;

  modport master (output counter, load, on_count, input active, elapsed);
  modport slave  (input counter, load, on_count, output active, elapsed);
endinterface
`default_nettype wire

// File: rtl/range_counter.sv
`default_nettype none
// ============================================================================
// Module   : range_counter
// Purpose  : Opens a window of RANGE_DURATION clocks when the external
//            counter equals a loaded start value, reporting elapsed cycles.
// Ports    : clock - system clock, rising edge
//            reset - synchronous, active-high
//            bus   - range_counter_if.slave (counter, load, on_count in;
//                    active, elapsed out, both registered)
// Revision : 1.0 - initial release
// ============================================================================
module range_counter #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int ELAPSED_WIDTH  = 4,
  parameter int RANGE_DURATION = 6
) (
  input  wire logic       clock,
  input  wire logic       reset,
  range_counter_if.slave  bus
);

  if (RANGE_DURATION < 1 || RANGE_DURATION > (1 << ELAPSED_WIDTH)) begin : g_bad_range
    $error("range_counter: RANGE_DURATION must lie in 1 .. 2**ELAPSED_WIDTH");
  end

  // Terminal elapsed value; fits because RANGE_DURATION <= 2**ELAPSED_WIDTH.
  localparam logic [ELAPSED_WIDTH-1:0] c_last = ELAPSED_WIDTH'(RANGE_DURATION - 1);
  localparam logic [ELAPSED_WIDTH-1:0] c_one  = ELAPSED_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] start_q, start_d;
  logic                     active_q, active_d;
  logic [ELAPSED_WIDTH-1:0] elapsed_q, elapsed_d;

  always_comb begin
    start_d   = start_q;
    active_d  = active_q;
    elapsed_d = elapsed_q;
    if (bus.load) begin
      // A load aborts any open window; the new start is only compared
      // from the next edge onward.
      start_d   = bus.on_count;
      active_d  = 1'b0;
      elapsed_d = '0;
    end else if (!active_q) begin
      if (bus.counter == start_q) begin
        active_d  = 1'b1;
        elapsed_d = '0;
      end
    end else if (elapsed_q == c_last) begin
      // Window closes; matches seen while open were ignored, so the
      // earliest retrigger is the following edge.
      active_d  = 1'b0;
      elapsed_d = '0;
    end else begin
      elapsed_d = elapsed_q + c_one;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q   <= '0;
      active_q  <= 1'b0;
      elapsed_q <= '0;
    end else begin
      start_q   <= start_d;
      active_q  <= active_d;
      elapsed_q <= elapsed_d;
    end
  end

  assign bus.active  = active_q;
  assign bus.elapsed = elapsed_q;

endmodule
`default_nettype wire

// File: tb/tb_range_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_counter
// Purpose  : Self-checking bench for range_counter. Two instances share one
//            stimulus stream: one with a 6-cycle window, one with a 1-cycle
//            window. A reference model predicts each cycle's outputs into a
//            scoreboard queue; a monitor pops and compares after every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_counter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  range_counter_if #(.COUNTER_WIDTH(8), .ELAPSED_WIDTH(4)) bus6 ();
  range_counter_if #(.COUNTER_WIDTH(8), .ELAPSED_WIDTH(4)) bus1 ();

  range_counter #(.COUNTER_WIDTH(8), .ELAPSED_WIDTH(4), .RANGE_DURATION(6)) dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (bus6.slave)
  );

  range_counter #(.COUNTER_WIDTH(8), .ELAPSED_WIDTH(4), .RANGE_DURATION(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct packed {
    logic       a6;
    logic [3:0] e6;
    logic       a1;
    logic [3:0] e1;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model: m_left = window cycles still to be shown (including the current one).
  int         m_left [2] = '{0, 0};
  logic [7:0] m_start[2] = '{8'd0, 8'd0};
  int         m_dur  [2] = '{6, 1};

  // Drive one cycle of stimulus, predict the post-edge outputs, advance one edge.
  task automatic step(input logic rst, input logic ld, input logic [7:0] oc, input logic [7:0] cnt);
    exp_t e;
    reset = rst;
    bus6.load = ld; bus6.on_count = oc; bus6.counter = cnt;
    bus1.load = ld; bus1.on_count = oc; bus1.counter = cnt;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_start[k] = 8'd0; m_left[k] = 0;
      end else if (ld) begin
        m_start[k] = oc;   m_left[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
      end else if (cnt == m_start[k]) begin
        m_left[k] = m_dur[k];
      end
    end
    e.a6 = (m_left[0] > 0);
    e.e6 = (m_left[0] > 0) ? 4'(m_dur[0] - m_left[0]) : 4'd0;
    e.a1 = (m_left[1] > 0);
    e.e1 = (m_left[1] > 0) ? 4'(m_dur[1] - m_left[1]) : 4'd0;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer: one expected entry per clock edge.
  always begin : monitor
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus6.active !== e.a6 || bus6.elapsed !== e.e6) begin
        n_fail++;
        $display("FAIL sb_dur6 t=%0t counter=%0d: got active=%b elapsed=%0d, want active=%b elapsed=%0d",
                 $time, bus6.counter, bus6.active, bus6.elapsed, e.a6, e.e6);
      end
      n_cmp++;
      if (bus1.active !== e.a1 || bus1.elapsed !== e.e1) begin
        n_fail++;
        $display("FAIL sb_dur1 t=%0t counter=%0d: got active=%b elapsed=%0d, want active=%b elapsed=%0d",
                 $time, bus1.counter, bus1.active, bus1.elapsed, e.a1, e.e1);
      end
    end
  end

  // Sweep the counter and gather window statistics of the 6-cycle instance.
  task automatic sweep(input int lo, input int hi, output int first_rise, output int n_rise, output int n_high);
    logic prev;
    prev = bus6.active;
    first_rise = -1; n_rise = 0; n_high = 0;
    for (int c = lo; c <= hi; c++) begin
      step(1'b0, 1'b0, 8'd0, 8'(c));
      if (bus6.active && !prev) begin
        n_rise++;
        if (first_rise < 0) first_rise = c;
      end
      if (bus6.active) n_high++;
      prev = bus6.active;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 8'd0, 8'd0);
    n_cmp++;
    if (bus6.active !== 1'b0 || bus6.elapsed !== 4'd0 || bus1.active !== 1'b0 || bus1.elapsed !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got a6=%b e6=%0d a1=%b e1=%0d, want all 0",
               bus6.active, bus6.elapsed, bus1.active, bus1.elapsed);
    end
  endtask

  task automatic test_trigger();
    int r, nr, nh;
    step(1'b0, 1'b1, 8'd10, 8'd0);
    sweep(0, 120, r, nr, nh);
    n_cmp++;
    if (r != 10 || nr != 1 || nh != 6) begin
      n_fail++;
      $display("FAIL trigger10: got rise_at=%0d windows=%0d high=%0d, want 10/1/6", r, nr, nh);
    end
  endtask

  task automatic test_load_idle();
    int r, nr, nh;
    step(1'b0, 1'b1, 8'd200, 8'd121);
    sweep(0, 255, r, nr, nh);
    n_cmp++;
    if (r != 200 || nr != 1 || nh != 6) begin
      n_fail++;
      $display("FAIL load_idle200: got rise_at=%0d windows=%0d high=%0d, want 200/1/6", r, nr, nh);
    end
  endtask

  task automatic test_abort_load();
    int r, nr, nh;
    bit found;
    found = 1'b0;
    step(1'b0, 1'b0, 8'd0, 8'd200);
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus6.active === 1'b1 && bus6.elapsed === 4'd3) found = 1'b1;
      else step(1'b0, 1'b0, 8'd0, 8'd201);
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_wait: got elapsed=%0d active=%b, want elapsed=3 within 10 cycles", bus6.elapsed, bus6.active);
    end
    step(1'b0, 1'b1, 8'd50, 8'd202);
    n_cmp++;
    if (bus6.active !== 1'b0 || bus6.elapsed !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_load: got active=%b elapsed=%0d, want 0/0", bus6.active, bus6.elapsed);
    end
    sweep(40, 70, r, nr, nh);
    n_cmp++;
    if (r != 50 || nr != 1 || nh != 6) begin
      n_fail++;
      $display("FAIL after_abort50: got rise_at=%0d windows=%0d high=%0d, want 50/1/6", r, nr, nh);
    end
  endtask

  task automatic test_hold_match();
    int nr, nh, gap, gap_min, gap_max;
    logic prev;
    prev = bus6.active;
    nr = 0; nh = 0; gap = 0; gap_min = 999; gap_max = -1;
    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b0, 8'd0, 8'd50);
      if (bus6.active) begin
        if (!prev) begin
          nr++;
          if (nr > 1) begin
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
          end
        end
        nh++;
        gap = 0;
      end else begin
        gap++;
      end
      prev = bus6.active;
    end
    n_cmp++;
    if (nr != 4 || nh != 24 || gap_min != 1 || gap_max != 1) begin
      n_fail++;
      $display("FAIL hold_match: got windows=%0d high=%0d gap_min=%0d gap_max=%0d, want 4/24/1/1",
               nr, nh, gap_min, gap_max);
    end
  endtask

  task automatic test_reset_mid();
    int r, nr, nh;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b0, 8'd0, 8'd50);
      if (bus6.active === 1'b1 && bus6.elapsed === 4'd2) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got elapsed=%0d active=%b, want elapsed=2 within 12 cycles", bus6.elapsed, bus6.active);
    end
    step(1'b1, 1'b0, 8'd0, 8'd50);
    n_cmp++;
    if (bus6.active !== 1'b0 || bus6.elapsed !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got active=%b elapsed=%0d, want 0/0", bus6.active, bus6.elapsed);
    end
    // Start register is back at 0, so counter==0 opens a window.
    step(1'b0, 1'b0, 8'd0, 8'd0);
    n_cmp++;
    if (bus6.active !== 1'b1 || bus6.elapsed !== 4'd0) begin
      n_fail++;
      $display("FAIL start_after_reset: got active=%b elapsed=%0d, want 1/0", bus6.active, bus6.elapsed);
    end
    step(1'b0, 1'b1, 8'd10, 8'd0);
    sweep(0, 120, r, nr, nh);
    n_cmp++;
    if (r != 10 || nr != 1 || nh != 6) begin
      n_fail++;
      $display("FAIL repeat_trigger10: got rise_at=%0d windows=%0d high=%0d, want 10/1/6", r, nr, nh);
    end
  endtask

  task automatic test_dur1();
    int nr, nh, bad_e;
    logic prev;
    prev = bus1.active;
    nr = 0; nh = 0; bad_e = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'd0, 8'd10);
      if (bus1.active && !prev) nr++;
      if (bus1.active) begin
        nh++;
        if (bus1.elapsed !== 4'd0) bad_e++;
      end
      prev = bus1.active;
    end
    n_cmp++;
    if (nr != 5 || nh != 5 || bad_e != 0) begin
      n_fail++;
      $display("FAIL dur1_pulses: got pulses=%0d high=%0d nonzero_elapsed=%0d, want 5/5/0", nr, nh, bad_e);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus6.load = 1'b0; bus6.on_count = 8'd0; bus6.counter = 8'd0;
    bus1.load = 1'b0; bus1.on_count = 8'd0; bus1.counter = 8'd0;
    test_reset();
    test_trigger();
    test_load_idle();
    test_abort_load();
    test_hold_match();
    test_reset_mid();
    test_dur1();
    @(posedge clock);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
